mem_stage: RTL and testbench

- Memory-access pipeline stage between the execute stage and the write-back stage of the RISC-V core.
- Accepts one executed instruction at a time. Loads and stores go to the data memory over a request/acknowledge handshake. ALU and branch results pass straight through.
- Produces the registered result/load-data bundle that write-back consumes.
- Stalls the upstream stage while a memory transaction is outstanding.

---
 rtl/mem_stage.sv | 180 ++++++++++++++++++
 tb/tb_mem_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: forwards ALU/branch results and runs one
// load/store request/acknowledge transaction at a time toward write-back.
module mem_stage #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned INST_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [1:0]        i_type,
    input  logic [DATA_W-1:0] i_result,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [4:0]        i_rd_id,
    output logic              o_stall,
    output logic              o_d_req,
    output logic              o_d_we,
    output logic [ADDR_W-1:0] o_d_addr,
    output logic [DATA_W-1:0] o_d_wdata,
    input  logic              i_d_ack,
    input  logic [DATA_W-1:0] i_d_rdata,
    output logic [DATA_W-1:0] o_data,
    output logic [4:0]        o_rd_id,
    output logic [1:0]        o_type,
    output logic              o_valid,
    output logic              o_d_valid_data,
    output logic [DATA_W-1:0] o_d_data
);

    localparam logic [1:0] TYPE_LOAD  = 2'd0;
    localparam logic [1:0] TYPE_STORE = 2'd1;

    // The address is taken from the low bits of the result bus.
    if (ADDR_W > DATA_W || INST_W == 0) begin : g_param_check
        $error("mem_stage: ADDR_W must not exceed DATA_W and INST_W must be nonzero");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_WAIT  = 2'd1,
        STORE_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                stall_q, stall_d;
    logic                d_req_q, d_req_d;
    logic                d_we_q, d_we_d;
    logic [ADDR_W-1:0]   d_addr_q, d_addr_d;
    logic [DATA_W-1:0]   d_wdata_q, d_wdata_d;
    logic [4:0]          ld_rd_q, ld_rd_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [4:0]          rd_id_q, rd_id_d;
    logic [1:0]          type_q, type_d;
    logic                valid_q, valid_d;
    logic                d_valid_data_q, d_valid_data_d;
    logic [DATA_W-1:0]   d_data_q, d_data_d;
    logic                ack_c;

    // Ack only counts against a request that is already visible to memory.
    assign ack_c = i_d_ack && d_req_q;

    // Next-state and registered-output logic; result fields are pulses.
    always_comb begin
        state_d        = state_q;
        d_req_d        = d_req_q;
        d_we_d         = d_we_q;
        d_addr_d       = d_addr_q;
        d_wdata_d      = d_wdata_q;
        ld_rd_d        = ld_rd_q;
        data_d         = '0;
        rd_id_d        = '0;
        type_d         = '0;
        valid_d        = 1'b0;
        d_valid_data_d = 1'b0;
        d_data_d       = '0;

        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    unique case (i_type)
                        TYPE_LOAD: begin
                            d_req_d   = 1'b1;
                            d_we_d    = 1'b0;
                            d_addr_d  = ADDR_W'(i_result);
                            d_wdata_d = '0;
                            ld_rd_d   = i_rd_id;
                            state_d   = LOAD_WAIT;
                        end
                        TYPE_STORE: begin
                            d_req_d   = 1'b1;
                            d_we_d    = 1'b1;
                            d_addr_d  = ADDR_W'(i_result);
                            d_wdata_d = i_store_data;
                            ld_rd_d   = '0;
                            state_d   = STORE_WAIT;
                        end
                        default: begin
                            valid_d = 1'b1;
                            data_d  = i_result;
                            rd_id_d = i_rd_id;
                            type_d  = i_type;
                        end
                    endcase
                end
            end
            LOAD_WAIT: begin
                if (ack_c) begin
                    d_req_d        = 1'b0;
                    d_we_d         = 1'b0;
                    d_addr_d       = '0;
                    d_wdata_d      = '0;
                    d_valid_data_d = 1'b1;
                    d_data_d       = i_d_rdata;
                    rd_id_d        = ld_rd_q;
                    type_d         = TYPE_LOAD;
                    state_d        = IDLE;
                end
            end
            STORE_WAIT: begin
                if (ack_c) begin
                    d_req_d   = 1'b0;
                    d_we_d    = 1'b0;
                    d_addr_d  = '0;
                    d_wdata_d = '0;
                    valid_d   = 1'b1;
                    type_d    = TYPE_STORE;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        stall_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= IDLE;
            stall_q        <= 1'b0;
            d_req_q        <= 1'b0;
            d_we_q         <= 1'b0;
            d_addr_q       <= '0;
            d_wdata_q      <= '0;
            ld_rd_q        <= '0;
            data_q         <= '0;
            rd_id_q        <= '0;
            type_q         <= '0;
            valid_q        <= 1'b0;
            d_valid_data_q <= 1'b0;
            d_data_q       <= '0;
        end else begin
            state_q        <= state_d;
            stall_q        <= stall_d;
            d_req_q        <= d_req_d;
            d_we_q         <= d_we_d;
            d_addr_q       <= d_addr_d;
            d_wdata_q      <= d_wdata_d;
            ld_rd_q        <= ld_rd_d;
            data_q         <= data_d;
            rd_id_q        <= rd_id_d;
            type_q         <= type_d;
            valid_q        <= valid_d;
            d_valid_data_q <= d_valid_data_d;
            d_data_q       <= d_data_d;
        end
    end

    assign o_stall        = stall_q;
    assign o_d_req        = d_req_q;
    assign o_d_we         = d_we_q;
    assign o_d_addr       = d_addr_q;
    assign o_d_wdata      = d_wdata_q;
    assign o_data         = data_q;
    assign o_rd_id        = rd_id_q;
    assign o_type         = type_q;
    assign o_valid        = valid_q;
    assign o_d_valid_data = d_valid_data_q;
    assign o_d_data       = d_data_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: table-driven transactions plus hand-written corner
// sequences, with a result scoreboard checked on every falling edge.
module tb_mem_stage;

    localparam int unsigned ADDR_W = 64;
    localparam int unsigned INST_W = 32;
    localparam int unsigned DATA_W = 64;

    logic              i_clk;
    logic              i_rst_n;
    logic              i_valid;
    logic [1:0]        i_type;
    logic [DATA_W-1:0] i_result;
    logic [DATA_W-1:0] i_store_data;
    logic [4:0]        i_rd_id;
    logic              o_stall;
    logic              o_d_req;
    logic              o_d_we;
    logic [ADDR_W-1:0] o_d_addr;
    logic [DATA_W-1:0] o_d_wdata;
    logic              i_d_ack;
    logic [DATA_W-1:0] i_d_rdata;
    logic [DATA_W-1:0] o_data;
    logic [4:0]        o_rd_id;
    logic [1:0]        o_type;
    logic              o_valid;
    logic              o_d_valid_data;
    logic [DATA_W-1:0] o_d_data;

    mem_stage #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DATA_W(DATA_W)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_valid        (i_valid),
        .i_type         (i_type),
        .i_result       (i_result),
        .i_store_data   (i_store_data),
        .i_rd_id        (i_rd_id),
        .o_stall        (o_stall),
        .o_d_req        (o_d_req),
        .o_d_we         (o_d_we),
        .o_d_addr       (o_d_addr),
        .o_d_wdata      (o_d_wdata),
        .i_d_ack        (i_d_ack),
        .i_d_rdata      (i_d_rdata),
        .o_data         (o_data),
        .o_rd_id        (o_rd_id),
        .o_type         (o_type),
        .o_valid        (o_valid),
        .o_d_valid_data (o_d_valid_data),
        .o_d_data       (o_d_data)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        is_load;
        logic [63:0] data;
        logic [4:0]  rd;
        logic [1:0]  typ;
    } exp_t;

    typedef struct {
        logic [1:0]  typ;
        logic [63:0] result;
        logic [63:0] sdata;
        logic [4:0]  rd;
        logic [63:0] rdata;
        int          ack_delay;
        logic        exp_load;
        logic [63:0] exp_data;
        logic [4:0]  exp_rd;
        logic [1:0]  exp_type;
    } vec_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every result pulse must match the oldest pending expectation.
    always @(negedge i_clk) begin
        if (mon_en) begin
            check("pulse_exclusive", 64'(o_valid & o_d_valid_data), 64'd0);
            if (o_valid || o_d_valid_data) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got o_valid=%0b o_d_valid_data=%0b expected none at %0t",
                             o_valid, o_d_valid_data, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("res_is_load", 64'(o_d_valid_data), 64'(e.is_load));
                    if (e.is_load) check("res_d_data", o_d_data, e.data);
                    else           check("res_data", o_data, e.data);
                    check("res_rd", 64'(o_rd_id), 64'(e.rd));
                    check("res_type", 64'(o_type), 64'(e.typ));
                end
            end else begin
                check("idle_data", o_data | o_d_data, 64'd0);
                check("idle_meta", 64'({o_rd_id, o_type}), 64'd0);
            end
        end
    end

    task automatic push_exp(input logic is_load, input logic [63:0] data,
                            input logic [4:0] rd, input logic [1:0] typ);
        exp_t e;
        e.is_load = is_load;
        e.data    = data;
        e.rd      = rd;
        e.typ     = typ;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [1:0] typ, input logic [63:0] res,
                         input logic [63:0] sdata, input logic [4:0] rd);
        i_valid      = 1'b1;
        i_type       = typ;
        i_result     = res;
        i_store_data = sdata;
        i_rd_id      = rd;
    endtask

    task automatic idle_inputs();
        i_valid      = 1'b0;
        i_type       = 2'd0;
        i_result     = '0;
        i_store_data = '0;
        i_rd_id      = '0;
    endtask

    task automatic do_txn(input vec_t v);
        @(negedge i_clk);
        drive(v.typ, v.result, v.sdata, v.rd);
        push_exp(v.exp_load, v.exp_data, v.exp_rd, v.exp_type);
        @(negedge i_clk);
        idle_inputs();
        if (v.typ < 2'd2) begin
            for (int k = 0; k <= v.ack_delay; k++) begin
                check("req_held", 64'(o_d_req), 64'd1);
                check("stall_held", 64'(o_stall), 64'd1);
                check("req_we", 64'(o_d_we), 64'(v.typ == 2'd1));
                check("req_addr", o_d_addr, v.result);
                if (v.typ == 2'd1) check("req_wdata", o_d_wdata, v.sdata);
                if (k == v.ack_delay) begin
                    i_d_ack   = 1'b1;
                    i_d_rdata = v.rdata;
                end
                @(negedge i_clk);
            end
            i_d_ack   = 1'b0;
            i_d_rdata = '0;
            check("req_drop", 64'(o_d_req), 64'd0);
            check("stall_drop", 64'(o_stall), 64'd0);
        end else begin
            check("alu_no_stall", 64'(o_stall), 64'd0);
            check("alu_no_req", 64'(o_d_req), 64'd0);
        end
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{2'd3, 64'h1234, 64'h0, 5'd5, 64'h0, 0, 1'b0, 64'h1234, 5'd5, 2'd3};
        vecs[1] = '{2'd0, 64'h80, 64'h0, 5'd7, 64'hDEADBEEF, 3, 1'b1, 64'hDEADBEEF, 5'd7, 2'd0};
        vecs[2] = '{2'd1, 64'h40, 64'hAA, 5'd9, 64'h0, 0, 1'b0, 64'h0, 5'd0, 2'd1};
        vecs[3] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 5'd0, 64'h0, 0, 1'b0,
                    64'hFFFF_FFFF_FFFF_FFFF, 5'd0, 2'd2};
        vecs[4] = '{2'd3, 64'h5555, 64'h0, 5'd0, 64'h0, 0, 1'b0, 64'h5555, 5'd0, 2'd3};
        vecs[5] = '{2'd0, 64'h7, 64'h0, 5'd31, 64'h0123_4567_89AB_CDEF, 1, 1'b1,
                    64'h0123_4567_89AB_CDEF, 5'd31, 2'd0};
        vecs[6] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hCAFE, 5'd3, 64'h0, 2, 1'b0, 64'h0, 5'd0, 2'd1};

        i_rst_n   = 1'b0;
        i_d_ack   = 1'b0;
        i_d_rdata = '0;
        idle_inputs();
        repeat (2) @(negedge i_clk);
        check("rst_stall", 64'(o_stall), 64'd0);
        check("rst_req", 64'({o_d_req, o_d_we}), 64'd0);
        check("rst_addr", o_d_addr | o_d_wdata, 64'd0);
        check("rst_valids", 64'({o_valid, o_d_valid_data}), 64'd0);
        check("rst_data", o_data | o_d_data, 64'd0);
        check("rst_meta", 64'({o_rd_id, o_type}), 64'd0);
        i_rst_n = 1'b1;
        mon_en  = 1'b1;

        for (int i = 0; i < 7; i++) do_txn(vecs[i]);

        // Back-to-back pass-through instructions.
        @(negedge i_clk);
        drive(2'd3, 64'hA, 64'h0, 5'd1);
        push_exp(1'b0, 64'hA, 5'd1, 2'd3);
        @(negedge i_clk);
        drive(2'd2, 64'hB, 64'h0, 5'd2);
        push_exp(1'b0, 64'hB, 5'd2, 2'd2);
        @(negedge i_clk);
        idle_inputs();

        // ALU instruction arriving during LOAD_WAIT is dropped; then an ALU
        // op issued in the same cycle as the load result is accepted.
        @(negedge i_clk);
        drive(2'd0, 64'h100, 64'h0, 5'd12);
        push_exp(1'b1, 64'h77, 5'd12, 2'd0);
        @(negedge i_clk);
        idle_inputs();
        check("inj_req", 64'(o_d_req), 64'd1);
        drive(2'd3, 64'h999, 64'h0, 5'd4);
        @(negedge i_clk);
        idle_inputs();
        check("inj_no_valid", 64'(o_valid), 64'd0);
        check("inj_req_held", 64'(o_d_req), 64'd1);
        check("inj_addr_held", o_d_addr, 64'h100);
        check("inj_we_held", 64'(o_d_we), 64'd0);
        i_d_ack   = 1'b1;
        i_d_rdata = 64'h77;
        @(negedge i_clk);
        i_d_ack   = 1'b0;
        i_d_rdata = '0;
        check("inj_stall_drop", 64'(o_stall), 64'd0);
        drive(2'd3, 64'h42, 64'h0, 5'd6);
        push_exp(1'b0, 64'h42, 5'd6, 2'd3);
        @(negedge i_clk);
        idle_inputs();

        // Stray acknowledge while idle.
        @(negedge i_clk);
        i_d_ack   = 1'b1;
        i_d_rdata = 64'hBAD;
        @(negedge i_clk);
        i_d_ack   = 1'b0;
        i_d_rdata = '0;
        check("stray_stall", 64'(o_stall), 64'd0);
        check("stray_req", 64'(o_d_req), 64'd0);
        check("stray_valids", 64'({o_valid, o_d_valid_data}), 64'd0);

        // Reset during STORE_WAIT, then a late ack that must be ignored.
        @(negedge i_clk);
        drive(2'd1, 64'h200, 64'h5, 5'd8);
        push_exp(1'b0, 64'h0, 5'd0, 2'd1);
        @(negedge i_clk);
        idle_inputs();
        check("sw_req", 64'(o_d_req), 64'd1);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("sw_rst_req", 64'(o_d_req), 64'd0);
        check("sw_rst_stall", 64'(o_stall), 64'd0);
        check("sw_rst_addr", o_d_addr | o_d_wdata, 64'd0);
        exp_q.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_d_ack = 1'b1;
        @(negedge i_clk);
        i_d_ack = 1'b0;
        check("sw_late_req", 64'(o_d_req), 64'd0);
        check("sw_late_stall", 64'(o_stall), 64'd0);
        check("sw_late_valid", 64'(o_valid), 64'd0);

        repeat (3) @(negedge i_clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
